// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: sequences word addresses into instruction
// memory and presents one instruction at a time over a valid/ready handshake.
module fetch_ctrl #(
  parameter int unsigned DEPTH   = 101,
  parameter logic [5:0]  HALT_OP = 6'b111111
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_addr,
  output logic        halted,
  output logic        overrun
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_INIT,
    S_FETCH,
    S_HALTED
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_pc;
  logic [31:0] r_inst;
  logic [31:0] r_inst_pc;
  logic        r_valid;
  logic        r_halted;
  logic        r_overrun;

  logic w_fetch;
  logic w_stall;
  logic w_past_end;
  logic w_cap;
  logic w_ovr_hit;
  logic w_halt_op;

  always_comb begin
    w_fetch    = (r_state == S_FETCH);
    w_stall    = r_valid && !inst_ready;
    w_past_end = (r_pc >= 32'(DEPTH));
    w_halt_op  = (imem_data[31:26] == HALT_OP);
    w_cap      = w_fetch && !redirect && !w_stall
                 && !w_past_end;
    w_ovr_hit  = w_fetch && !redirect && !w_stall
                 && w_past_end;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (start) w_next = S_INIT;
      S_INIT:   w_next = S_FETCH;
      S_FETCH:  begin
        if (w_ovr_hit || (w_cap && w_halt_op))
          w_next = S_HALTED;
      end
      S_HALTED: if (start) w_next = S_INIT;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc      <= '0;
      r_inst    <= '0;
      r_inst_pc <= '0;
      r_valid   <= 1'b0;
      r_halted  <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      unique case (r_state)
        S_INIT: begin
          r_pc    <= '0;
          r_valid <= 1'b0;
        end
        S_FETCH: begin
          // redirect flushes whatever is held, even mid-stall
          if (redirect) begin
            r_pc    <= redirect_addr;
            r_valid <= 1'b0;
          end else if (w_cap) begin
            r_inst    <= imem_data;
            r_inst_pc <= r_pc;
            r_valid   <= 1'b1;
            r_pc      <= r_pc + 32'd1;
            if (w_halt_op) r_halted <= 1'b1;
          end else if (w_ovr_hit) begin
            r_valid   <= 1'b0;
            r_halted  <= 1'b1;
            r_overrun <= 1'b1;
          end
        end
        S_HALTED: begin
          if (start) begin
            r_halted  <= 1'b0;
            r_overrun <= 1'b0;
            r_valid   <= 1'b0;
          end else if (r_valid && inst_ready) begin
            r_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign imem_addr  = (r_state == S_FETCH || r_state == S_HALTED)
                      ? r_pc : 32'd0;
  assign inst       = r_inst;
  assign inst_pc    = r_inst_pc;
  assign inst_valid = r_valid;
  assign halted     = r_halted;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: sequencing, stall, redirect, halt,
// overrun and asynchronous reset, against a small behavioural memory.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic        redirect;
  logic [31:0] redirect_addr;
  logic        halted;
  logic        overrun;

  logic [31:0] mem [0:127];
  int errs = 0;
  int nchk = 0;

  always #5 clk = ~clk;

  assign imem_data = (imem_addr < 32'd128) ? mem[imem_addr[6:0]] : 32'h0;

  fetch_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .redirect(redirect),
    .redirect_addr(redirect_addr),
    .halted(halted), .overrun(overrun)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_inst(input string tag, input logic [31:0] pc);
    chk({tag, ".valid"}, 32'(inst_valid), 32'd1);
    chk({tag, ".pc"}, inst_pc, pc);
    chk({tag, ".inst"}, inst, mem[pc[6:0]]);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 32'h1000_0000 | 32'(i);
    mem[0] = 32'h0000_0000;
    mem[1] = 32'h4C00_007B;
    mem[2] = 32'h4C01_0159;
    mem[4] = 32'hFC00_0000;

    rst_n = 1'b0; start = 1'b0; inst_ready = 1'b1;
    redirect = 1'b0; redirect_addr = '0;
    #12;
    chk("rst.valid", 32'(inst_valid), 32'd0);
    chk("rst.addr", imem_addr, 32'd0);
    chk("rst.halted", 32'(halted), 32'd0);
    chk("rst.inst", inst, 32'd0);
    rst_n = 1'b1;
    step();

    // run 0..4, word 4 is the halt opcode
    start = 1'b1;
    step();
    start = 1'b0;
    chk("init.valid", 32'(inst_valid), 32'd0);
    step();
    chk("fetch0.addr", imem_addr, 32'd0);
    chk("fetch0.valid", 32'(inst_valid), 32'd0);
    step(); chk_inst("seq0", 32'd0);
    step(); chk_inst("seq1", 32'd1);
    step(); chk_inst("seq2", 32'd2);
    step(); chk_inst("seq3", 32'd3);
    chk("seq3.halted", 32'(halted), 32'd0);
    step(); chk_inst("halt4", 32'd4);
    chk("halt4.halted", 32'(halted), 32'd1);
    chk("halt4.addr", imem_addr, 32'd5);
    step();
    chk("halt.drain", 32'(inst_valid), 32'd0);
    chk("halt.addr1", imem_addr, 32'd5);
    step();
    chk("halt.addr2", imem_addr, 32'd5);
    chk("halt.hold", 32'(halted), 32'd1);
    chk("halt.ovr", 32'(overrun), 32'd0);

    // restart, then stall at inst_pc=1
    start = 1'b1;
    step();
    start = 1'b0;
    chk("rs.halted", 32'(halted), 32'd0);
    step();
    step(); chk_inst("rs0", 32'd0);
    step(); chk_inst("rs1", 32'd1);
    inst_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk_inst("stall1", 32'd1);
      chk("stall1.addr", imem_addr, 32'd2);
    end
    inst_ready = 1'b1;
    step(); chk_inst("rel2", 32'd2);

    // redirect to 5 during stall at inst_pc=2
    inst_ready = 1'b0;
    redirect = 1'b1; redirect_addr = 32'd5;
    step();
    redirect = 1'b0;
    chk("rd5.flush", 32'(inst_valid), 32'd0);
    chk("rd5.addr", imem_addr, 32'd5);
    step(); chk_inst("rd5", 32'd5);

    // redirect to last word -> overrun
    inst_ready = 1'b1;
    redirect = 1'b1; redirect_addr = 32'd100;
    step();
    redirect = 1'b0;
    chk("rd100.flush", 32'(inst_valid), 32'd0);
    step(); chk_inst("rd100", 32'd100);
    chk("rd100.halted", 32'(halted), 32'd0);
    step();
    chk("ovr.halted", 32'(halted), 32'd1);
    chk("ovr.ovr", 32'(overrun), 32'd1);
    chk("ovr.valid", 32'(inst_valid), 32'd0);
    step();
    chk("ovr.addr", imem_addr, 32'd101);

    // start again, then asynchronous reset mid-stream
    start = 1'b1;
    step();
    start = 1'b0;
    chk("rs2.ovr", 32'(overrun), 32'd0);
    step();
    step(); chk_inst("rs2_0", 32'd0);
    step(); chk_inst("rs2_1", 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.valid", 32'(inst_valid), 32'd0);
    chk("arst.inst", inst, 32'd0);
    chk("arst.pc", inst_pc, 32'd0);
    chk("arst.addr", imem_addr, 32'd0);
    chk("arst.halted", 32'(halted), 32'd0);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("idle.valid", 32'(inst_valid), 32'd0);
      chk("idle.addr", imem_addr, 32'd0);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step(); chk_inst("rs3_0", 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter DEPTH, default 101, SHALL be the number of instruction words; valid word addresses are 0..DEPTH-1.
REQ-002 Parameter HALT_OP, default 6'b111111, SHALL be the opcode (bits 31:26) that ends a program.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 start  input  1  level-sampled request to begin fetching from word 0.
REQ-006 imem_addr  output  32  word address to instruction memory.
REQ-007 imem_data  input  32  combinational read data for imem_addr.
REQ-008 inst  output  32  fetched instruction.
REQ-009 inst_pc  output  32  word address of inst.
REQ-010 inst_valid  output  1  inst/inst_pc hold a valid instruction.
REQ-011 inst_ready  input  1  consumer accepts inst when inst_valid && inst_ready at a rising edge.
REQ-012 redirect  input  1  branch/jump request, single-cycle pulse.
REQ-013 redirect_addr  input  32  target word address for redirect.
REQ-014 halted  output  1  program ended by HALT_OP or address overrun.
REQ-015 overrun  output  1  program ended because the PC reached DEPTH or beyond.

Function
REQ-016 States SHALL be IDLE, INIT, FETCH and HALTED, held in a registered state variable.
REQ-017 IDLE: imem_addr=0, inst_valid=0; start=1 -> INIT.
REQ-018 INIT: one cycle for the memory preload; PC set to 0; unconditional -> FETCH.
REQ-019 FETCH: imem_addr SHALL equal the PC register combinationally.
REQ-020 FETCH capture SHALL occur when inst_valid=0 or inst_ready=1: inst<=imem_data, inst_pc<=PC, inst_valid<=1, PC<=PC+1.
REQ-021 FETCH stall SHALL occur when inst_valid=1 and inst_ready=0: PC, inst, inst_pc and inst_valid hold.
REQ-022 Consumption without a new capture (halt/overrun paths only) SHALL clear inst_valid.
REQ-023 Redirect in FETCH SHALL take priority over capture and stall: PC<=redirect_addr, inst_valid<=0 (flush), no capture that cycle.
REQ-024 Redirect SHALL be ignored in IDLE, INIT and HALTED.
REQ-025 Redirect held high for consecutive cycles SHALL reload PC each cycle, with no capture until it deasserts.
REQ-026 A captured word with bits 31:26 == HALT_OP SHALL be presented normally, then the next state SHALL be HALTED; no further capture occurs.
REQ-027 In FETCH, if PC >= DEPTH and no capture-blocking stall exists, the block SHALL not capture, SHALL go to HALTED, and SHALL set overrun=1.
REQ-028 HALTED: halted=1; a pending inst_valid SHALL stay until accepted, then clear.
REQ-029 HALTED: start=1 SHALL go to INIT and clear halted and overrun.
REQ-030 start SHALL be ignored in INIT and FETCH.
REQ-031 Latency: start sampled at edge E0 gives INIT after E0, FETCH after E1, and inst_valid=1 with inst_pc=0 after E2.
REQ-032 Sustained throughput with inst_ready=1 SHALL be one instruction per cycle.
REQ-033 PC arithmetic SHALL be 32-bit unsigned, increment by 1 (word addressing), and wrap at 2^32 is unreachable (caught by REQ-027).

Reset
REQ-034 rst_n=0 SHALL immediately force state=IDLE, PC=0, inst=0, inst_pc=0, inst_valid=0, halted=0, overrun=0, and imem_addr=0.
REQ-035 Reset asserted mid-FETCH or mid-stall SHALL discard the pending instruction; fetching resumes only after a new start.

Verification
REQ-036 The bench SHALL apply: memory {0x00000000, 0x4C00007B, 0x4C010159}, start pulse, inst_ready=1 -> inst 0x00000000/0x4C00007B/0x4C010159 with inst_pc 0/1/2 on three consecutive cycles beginning two cycles after start.
REQ-037 The bench SHALL apply: inst_ready=0 for 3 cycles while inst_pc=1 -> inst, inst_pc and imem_addr (=2) stable; on release inst_pc=2 the next cycle, with no skip or duplicate.
REQ-038 The bench SHALL apply: redirect=1 with redirect_addr=5 during a stall at inst_pc=2 -> inst_valid=0 the next cycle, then inst_pc=5 with inst=mem[5]; word 3 is never presented.
REQ-039 The bench SHALL apply: mem[4]=0xFC000000 -> word 4 is presented, halted=1, imem_addr no longer advances; start then restarts at inst_pc=0 with halted=0.
REQ-040 The bench SHALL apply: redirect_addr=100 with DEPTH=101 -> word 100 is presented, then halted=1 and overrun=1.
REQ-041 The bench SHALL apply: rst_n=0 asynchronously mid-stream (between edges) -> all outputs zero before the next clock edge; start required to resume.
